// File: rtl/fifo_read_arbiter_if.sv
// Read-side bundle shared by the FIFO read controller, the requesters and the
// arbiter. The arbiter takes the master view; the environment takes the slave view.
interface fifo_read_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int DWIDTH = 8
);
    logic [NREQ-1:0]   req;
    logic              empty;
    logic              rden;
    logic [DWIDTH-1:0] rddata;
    logic              sync_flush;
    logic              remove;
    logic [NREQ-1:0]   gnt;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic [IDW-1:0]    dout_id;
    logic              busy;

    modport master (
        input  req, empty, rden, rddata, sync_flush,
        output remove, gnt, dout, dout_valid, dout_id, busy
    );

    modport slave (
        output req, empty, rden, rddata, sync_flush,
        input  remove, gnt, dout, dout_valid, dout_id, busy
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: hands the single FIFO read port to one requester at a
// time, round-robin, for bursts of at most BURST pops, and tags every word
// returned by the read controller with the index of the requester that owns it.
module fifo_read_arbiter #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int BURST  = 4,
    parameter int DWIDTH = 8
) (
    input  logic                clk_out,
    input  logic                rst,
    fifo_read_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [IDW-1:0]    owner;
    logic [IDW-1:0]    last;
    logic [IDW-1:0]    tag;
    logic [3:0]        cnt;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic [IDW-1:0]    dout_id;

    logic [IDW-1:0]    winner;
    logic [IDW-1:0]    idx;
    logic              found;
    logic              can_pop;

    // Round-robin pick: first asserted request scanning upward from last+1, wrapping
    always_comb begin
        winner = last;
        idx    = last;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = last + IDW'(i + 1);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // The owner may pop while it still wants data, the FIFO has data and credit remains;
    // a flush kills the pop in the very cycle it appears
    assign can_pop    = bus.req[owner] & ~bus.empty & (cnt < 4'(BURST));
    assign bus.remove = (state == SERVE) & can_pop & ~bus.sync_flush;

    // Arbitration FSM: grant, burst counting, exit and flush handling with registered outputs
    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            owner <= '0;
            last  <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sync_flush) begin
                        state <= FLUSH;
                        last  <= IDW'(NREQ - 1);
                    end else if (|bus.req && !bus.empty) begin
                        state <= SERVE;
                        owner <= winner;
                        gnt   <= NREQ'(1) << winner;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SERVE: begin
                    if (bus.sync_flush) begin
                        state <= FLUSH;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        last  <= IDW'(NREQ - 1);
                    end else if (!can_pop) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        last  <= owner;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FLUSH: begin
                    last <= IDW'(NREQ - 1);
                    if (!bus.sync_flush) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Capture popped data one cycle after the pop, tagged with the owner of that pop
    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            tag        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_id    <= '0;
        end else begin
            tag <= owner;
            if (bus.rden) begin
                dout       <= bus.rddata;
                dout_valid <= 1'b1;
                dout_id    <= tag;
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

    assign bus.gnt        = gnt;
    assign bus.busy       = busy;
    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.dout_id    = dout_id;
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: models the read-side FIFO controller (pop one
// cycle after remove, rden plus data the next cycle) and scoreboards every
// popped word against the dout/dout_id the arbiter returns.
module tb_fifo_read_arbiter;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int BURST  = 4;
    localparam int DWIDTH = 8;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [IDW-1:0]    id;
    } exp_t;

    logic clk_out = 1'b0;
    logic rst     = 1'b0;

    fifo_read_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .DWIDTH(DWIDTH)) bus ();

    fifo_read_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .BURST(BURST), .DWIDTH(DWIDTH)
    ) dut (
        .clk_out(clk_out),
        .rst    (rst),
        .bus    (bus.master)
    );

    always #5 clk_out = ~clk_out;

    logic [DWIDTH-1:0] fifo_q[$];
    exp_t              sb_q[$];
    logic [IDW-1:0]    exp_id;
    logic [DWIDTH-1:0] next_word = 8'h10;
    int                checks = 0;
    int                errors = 0;
    int                dv_count = 0;
    logic              s_remove;
    logic [NREQ-1:0]   s_gnt;
    logic              s_busy;
    logic              s_dv;

    // One clock: sample mid-cycle, then model the read controller and check returned data
    task automatic tick();
        exp_t e;
        @(negedge clk_out);
        s_remove = bus.remove;
        s_gnt    = bus.gnt;
        s_busy   = bus.busy;
        s_dv     = bus.dout_valid;
        @(posedge clk_out);
        #1;
        if (bus.dout_valid === 1'b1) begin
            dv_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL dout_unexpected got id=%0d data=%0h expected no strobe", bus.dout_id, bus.dout);
            end else begin
                e = sb_q.pop_front();
                if (bus.dout !== e.data || bus.dout_id !== e.id) begin
                    errors++;
                    $display("[TB] FAIL dout got id=%0d data=%0h expected id=%0d data=%0h", bus.dout_id, bus.dout, e.id, e.data);
                end
            end
        end
        bus.rden = s_remove;
        if (s_remove === 1'b1) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                bus.rden = 1'b0;
                $display("[TB] FAIL remove_on_empty got remove=1 expected 0");
            end else begin
                bus.rddata = fifo_q.pop_front();
                e.data = bus.rddata;
                e.id   = exp_id;
                sb_q.push_back(e);
            end
        end else begin
            bus.rddata = DWIDTH'($urandom);
        end
        bus.empty = (fifo_q.size() == 0);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(next_word);
            next_word++;
        end
        bus.empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        bus.req        = '0;
        bus.empty      = 1'b1;
        bus.rden       = 1'b0;
        bus.rddata     = '0;
        bus.sync_flush = 1'b0;
        fifo_q.delete();
        sb_q.delete();
        dv_count = 0;
        repeat (2) @(posedge clk_out);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        bus.req = '0;
        repeat (6) tick();
    endtask

    // Tick until a grant is seen; n is the number of ticks it took
    task automatic wait_grant(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (s_gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Follow the current grant to its end, counting pop cycles
    task automatic count_grant(output int pops, output bit ok);
        ok   = 1'b0;
        pops = int'(s_remove);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_gnt == '0) begin
                ok = 1'b1;
                break;
            end
            pops += int'(s_remove);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = '0; bus.empty = 1'b1; bus.rden = 1'b0; bus.rddata = '0; bus.sync_flush = 1'b0;
        #2;
        checks++;
        if (bus.gnt !== '0 || bus.remove !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got gnt=%b remove=%b busy=%b expected 0 0 0", bus.gnt, bus.remove, bus.busy);
        end
        checks++;
        if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.dout_id !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got dout=%h valid=%b id=%0d expected 0 0 0", bus.dout, bus.dout_valid, bus.dout_id);
        end
        do_reset();
    endtask

    task automatic test_single_burst();
        bit ok; int n; int pops;
        do_reset();
        exp_id = 2'd0;
        bus.req = 4'b0001;
        fill(10);
        wait_grant(ok, n);
        checks++;
        if (!ok || s_gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL single_gnt got %b expected 0001", s_gnt);
        end
        count_grant(pops, ok);
        checks++;
        if (!ok || pops != BURST) begin
            errors++;
            $display("[TB] FAIL single_pops got %0d expected %0d", pops, BURST);
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle_busy got %b expected 0", s_busy);
        end
        wait_grant(ok, n);
        checks++;
        if (!ok || s_gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL single_regrant got %b expected 0001", s_gnt);
        end
        count_grant(pops, ok);
        checks++;
        if (!ok || pops != BURST) begin
            errors++;
            $display("[TB] FAIL single_pops2 got %0d expected %0d", pops, BURST);
        end
        drain();
        checks++;
        if (dv_count != 2 * BURST || sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_strobes got %0d pending %0d expected %0d pending 0", dv_count, sb_q.size(), 2 * BURST);
        end
    endtask

    task automatic test_round_robin();
        bit ok; int n; int pops;
        logic [NREQ-1:0] want;
        do_reset();
        bus.req = 4'b1111;
        fill(60);
        for (int k = 0; k < 5; k++) begin
            exp_id = IDW'(k % NREQ);
            want   = 4'b0001 << (k % NREQ);
            wait_grant(ok, n);
            checks++;
            if (!ok || s_gnt !== want) begin
                errors++;
                $display("[TB] FAIL rr_gnt[%0d] got %b expected %b", k, s_gnt, want);
            end
            count_grant(pops, ok);
            checks++;
            if (!ok || pops != BURST) begin
                errors++;
                $display("[TB] FAIL rr_pops[%0d] got %0d expected %0d", k, pops, BURST);
            end
        end
        drain();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rr_pending got %0d expected 0", sb_q.size());
        end
    endtask

    task automatic test_empty_stop();
        bit ok; int n;
        do_reset();
        exp_id = 2'd2;
        bus.req = 4'b0100;
        fill(2);
        wait_grant(ok, n);
        checks++;
        if (!ok || s_gnt !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL empty_gnt got %b expected 0100", s_gnt);
        end
        tick();
        tick();
        checks++;
        if (s_remove !== 1'b0 || s_gnt !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL empty_drop got remove=%b gnt=%b expected remove=0 gnt=0100", s_remove, s_gnt);
        end
        tick();
        checks++;
        if (s_gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL empty_gnt_clear got %b expected 0000", s_gnt);
        end
        drain();
        checks++;
        if (dv_count != 2 || sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL empty_strobes got %0d pending %0d expected 2 pending 0", dv_count, sb_q.size());
        end
    endtask

    task automatic test_flush();
        bit ok; int n; int pops;
        do_reset();
        exp_id = 2'd1;
        bus.req = 4'b0010;
        fill(20);
        wait_grant(ok, n);
        checks++;
        if (!ok || s_gnt !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL flush_first_gnt got %b expected 0010", s_gnt);
        end
        tick();
        bus.sync_flush = 1'b1;
        tick();
        checks++;
        if (s_remove !== 1'b0 || s_gnt !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL flush_remove got remove=%b gnt=%b expected remove=0 gnt=0010", s_remove, s_gnt);
        end
        bus.req = 4'b0011;
        exp_id  = 2'd0;
        tick();
        checks++;
        if (s_gnt !== '0 || s_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_state got gnt=%b busy=%b expected 0000 0", s_gnt, s_busy);
        end
        tick();
        checks++;
        if (s_dv !== 1'b0 || s_gnt !== '0) begin
            errors++;
            $display("[TB] FAIL flush_quiet got valid=%b gnt=%b expected 0 0000", s_dv, s_gnt);
        end
        bus.sync_flush = 1'b0;
        wait_grant(ok, n);
        checks++;
        if (!ok || s_gnt !== 4'b0001 || n != 3) begin
            errors++;
            $display("[TB] FAIL flush_regrant got gnt=%b after %0d expected 0001 after 3", s_gnt, n);
        end
        count_grant(pops, ok);
        drain();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL flush_pending got %0d expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok; int n;
        do_reset();
        exp_id = 2'd1;
        bus.req = 4'b0010;
        fill(20);
        wait_grant(ok, n);
        tick();
        tick();
        checks++;
        if (!ok || bus.busy !== 1'b1 || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_pre got busy=%b valid=%b expected 1 1", bus.busy, bus.dout_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== '0 || bus.remove !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_ctrl got gnt=%b remove=%b busy=%b expected 0 0 0", bus.gnt, bus.remove, bus.busy);
        end
        checks++;
        if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.dout_id !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_data got dout=%h valid=%b id=%0d expected 0 0 0", bus.dout, bus.dout_valid, bus.dout_id);
        end
        bus.rden = 1'b0;
        sb_q.delete();
        tick();
        tick();
        bus.req = 4'b1010;
        rst = 1'b1;
        wait_grant(ok, n);
        checks++;
        if (!ok || s_gnt !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL rstmid_first_gnt got %b expected 0010", s_gnt);
        end
        drain();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_pending got %0d expected 0", sb_q.size());
        end
    endtask

    task automatic test_req_drop();
        bit ok; int n; int pops;
        do_reset();
        exp_id = 2'd0;
        bus.req = 4'b0011;
        fill(20);
        wait_grant(ok, n);
        checks++;
        if (!ok || s_gnt !== 4'b0001 || s_remove !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_gnt got gnt=%b remove=%b expected 0001 1", s_gnt, s_remove);
        end
        bus.req = 4'b0010;
        tick();
        checks++;
        if (s_remove !== 1'b0 || s_gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL drop_end got remove=%b gnt=%b expected 0 0001", s_remove, s_gnt);
        end
        exp_id = 2'd1;
        wait_grant(ok, n);
        checks++;
        if (!ok || s_gnt !== 4'b0010 || n > 2) begin
            errors++;
            $display("[TB] FAIL drop_next got gnt=%b after %0d expected 0010 within 2", s_gnt, n);
        end
        count_grant(pops, ok);
        checks++;
        if (!ok || pops != BURST) begin
            errors++;
            $display("[TB] FAIL drop_next_pops got %0d expected %0d", pops, BURST);
        end
        drain();
        checks++;
        if (dv_count != 1 + BURST || sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drop_strobes got %0d pending %0d expected %0d pending 0", dv_count, sb_q.size(), 1 + BURST);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_empty_stop();
        test_flush();
        test_reset_mid_burst();
        test_req_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of read requesters sharing the FIFO read port (power of 2, 2..8).
REQ-002 Parameter IDW, default 2: requester-id width, equal to log2(NREQ).
REQ-003 Parameter BURST, default 4: maximum pops per grant (1..15).
REQ-004 Parameter DWIDTH, default 8: FIFO data width.
REQ-005 clk_out  input  1  read-domain clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 req  input  NREQ  per-requester pop request; level-sensitive, held until no longer needed.
REQ-008 empty  input  1  FIFO empty flag from the read-side controller.
REQ-009 rden  input  1  pop-executed strobe from the read-side controller.
REQ-010 rddata  input  DWIDTH  FIFO read data, valid in the cycle rden=1.
REQ-011 sync_flush  input  1  flush request, already synchronised to clk_out.
REQ-012 remove  output  1  pop request to the read-side controller.
REQ-013 gnt  output  NREQ  one-hot grant; all zero when no owner.
REQ-014 dout  output  DWIDTH  registered copy of rddata.
REQ-015 dout_valid  output  1  one-cycle strobe qualifying dout.
REQ-016 dout_id  output  IDW  requester index that owns dout.
REQ-017 busy  output  1  high while the state is SERVE.

Function
REQ-018 The FSM SHALL have the states IDLE, SERVE and FLUSH, binary encoded, with registered state.
REQ-019 IDLE: gnt=0 and remove=0.
REQ-020 IDLE transitions: sync_flush=1 goes to FLUSH; otherwise |req and !empty goes to SERVE; otherwise stay in IDLE.
REQ-021 Winner selection on the IDLE->SERVE edge SHALL be round-robin: the first asserted req scanning upward (mod NREQ) from last+1, where last is the previous winner.
REQ-022 Entering SERVE SHALL register the winner index in owner, set gnt to onehot(owner) and clear burst counter cnt (4 bits).
REQ-023 In SERVE, remove SHALL be combinational: remove = req[owner] & !empty & (cnt < BURST) & !sync_flush.
REQ-024 cnt SHALL increment in every cycle in which remove=1.
REQ-025 SERVE exit: sync_flush=1 goes to FLUSH; otherwise, in the cycle after remove would evaluate 0, go to IDLE with last <= owner. Causes of remove=0 are cnt==BURST, req[owner]=0 or empty=1.
REQ-026 gnt SHALL remain asserted through the SERVE cycle before exit and deassert in the first IDLE cycle.
REQ-027 FLUSH: gnt=0 and remove=0; stay while sync_flush=1, then go to IDLE; last SHALL be set to NREQ-1 so requester 0 is first priority afterwards.
REQ-028 Data path: every cycle rden=1, dout<=rddata, dout_valid<=1 and dout_id<=tag; tag is owner as registered on the previous cycle, so pops issued in the final SERVE cycle are still tagged correctly after exit.
REQ-029 dout_valid SHALL be 0 in any cycle not preceded by rden=1, including during FLUSH.
REQ-030 Simultaneous events: sync_flush SHALL have priority over everything else; when req and empty change in the same cycle, the new values SHALL be used combinationally for remove.
REQ-031 A requester dropping req mid-burst SHALL end its grant without penalty; unused burst credit SHALL be discarded.
REQ-032 No requester SHALL wait more than NREQ-1 grants while holding req asserted and the FIFO is non-empty.

Reset
REQ-033 While rst=0, asynchronously: state=IDLE, gnt=0, remove=0, busy=0, cnt=0, owner=0, last=NREQ-1, dout=0, dout_valid=0, dout_id=0, tag=0.
REQ-034 Reset asserted mid-burst SHALL abort the burst immediately; no dout_valid SHALL follow reset release until a new rden.
REQ-035 After reset release, the first grant SHALL go to the lowest-index asserted requester.

Verification
REQ-036 Bench SHALL cover: req=4'b0001, FIFO holding 10 words, BURST=4 -> exactly 4 remove cycles, then IDLE, then re-grant to req0; dout_id=0 on all 4 dout_valid strobes.
REQ-037 Bench SHALL cover: req=4'b1111 held, FIFO never empty -> grant order 0,1,2,3,0, each grant lasting 4 pops.
REQ-038 Bench SHALL cover: req=4'b0100 with the FIFO emptying after 2 pops -> remove drops the same cycle empty=1, gnt clears the next cycle, 2 dout_valid strobes with dout_id=2.
REQ-039 Bench SHALL cover: sync_flush pulsed for 3 cycles mid-burst (owner=1) -> remove=0 the same cycle, FLUSH held 3 cycles, next grant goes to req0 when req=4'b0011.
REQ-040 Bench SHALL cover: rst=0 asserted mid-SERVE -> all outputs 0 asynchronously; after release with req=4'b1010, first grant is gnt=4'b0010.
REQ-041 Bench SHALL cover: req[owner] deasserted after 1 pop -> grant ends, next asserted requester is granted within 2 cycles.
